hazard_ctrl: RTL

Pipeline hazard scheduler for the core_lapido 5-stage pipeline (IF, ID, EX, MEM, WB). Tracks the destination register of every in-flight register-writing instruction in EX, MEM and WB using a 3-entry shift-register scoreboard. Drives stall_pipeline and pc_write_enable to IF/ID for load-use and jr hazards. Branch flushes from MEM take priority over stalls. Exposes saturating stall and flush counters for performance measurement.

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_sat_counter.sv | 20 ++
 rtl/hazard_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the core_lapido hazard scheduler.
// Scoreboard slot indices and default field widths.
package hazard_ctrl_pkg;

  localparam int GRP_ADDR_WIDTH = 5;
  localparam int GRP_CNT_WIDTH  = 16;

  localparam int SB_DEPTH = 3;
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / jr hazard scheduler with an EX/MEM/WB destination
// scoreboard; taken branches in MEM override stalls.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = GRP_ADDR_WIDTH,
  parameter int CNT_W  = GRP_CNT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_jr,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              branch_taken,
  output logic              stall_pipeline,
  output logic              pc_write_enable,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  logic [SB_DEPTH-1:0] sb_v;
  logic [SB_DEPTH-1:0] sb_ld;
  logic [ADDR_W-1:0]   sb_dst [SB_DEPTH];

  logic ex_rs, ex_rt, mem_rs;
  logic load_use, jr_haz;
  logic ex_insert;

  assign ex_rs  = sb_v[SB_EX]  && (sb_dst[SB_EX]  == id_rs);
  assign ex_rt  = sb_v[SB_EX]  && (sb_dst[SB_EX]  == id_rt);
  assign mem_rs = sb_v[SB_MEM] && (sb_dst[SB_MEM] == id_rs);

  assign load_use = id_valid && sb_ld[SB_EX] &&
                    ((id_uses_rs && ex_rs) || (id_uses_rt && ex_rt));

  // WB needs no check: the register file writes through to ID reads.
  assign jr_haz = id_valid && id_is_jr && (ex_rs || mem_rs);

  assign stall_pipeline  = (load_use || jr_haz) && !branch_taken;
  assign pc_write_enable = ~stall_pipeline;

  assign ex_insert = id_valid && !stall_pipeline && !branch_taken;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_v  <= '0;
      sb_ld <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_dst[i] <= '0;
      end
    end else begin
      sb_v[SB_WB]    <= sb_v[SB_MEM];
      sb_ld[SB_WB]   <= sb_ld[SB_MEM];
      sb_dst[SB_WB]  <= sb_dst[SB_MEM];

      sb_v[SB_MEM]   <= sb_v[SB_EX]  && !branch_taken;
      sb_ld[SB_MEM]  <= sb_ld[SB_EX] && !branch_taken;
      sb_dst[SB_MEM] <= sb_dst[SB_EX];

      sb_v[SB_EX]    <= ex_insert && id_reg_write;
      sb_ld[SB_EX]   <= ex_insert && id_is_load;
      sb_dst[SB_EX]  <= ex_insert ? id_dst : '0;
    end
  end

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_pipeline),
    .count (stall_count)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_taken),
    .count (flush_count)
  );

endmodule
